friscv_io_bridge: RTL
=====================

Name: friscv_io_bridge

Overview:
- Upstream stage of the IO peripheral subsystem (GPIO/UART APB interconnect).
- Accepts load/store requests from the core's data-memory arbiter on a valid/ready request channel and drives them onto the IO master port (en/wr/addr/wdata/strb, rdata/ready).
- Returns one response per request on a valid/ready response channel.
- Rejects out-of-window addresses locally and bounds every bus access with a watchdog.

Parameters:
- ADDRW, 16, IO address width.
- XLEN, 32, data width; strobe width is XLEN/8.
- IO_BASE, 0, first byte address of the IO window.
- IO_SIZE, 2048, IO window size in bytes; a request hits when IO_BASE <= req_addr < IO_BASE+IO_SIZE.
- TIMEOUT, 255, maximum cycles mst_en may wait for mst_ready; must be >= 1.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset, active-low, synchronous (sampled on rising aclk edge only).
- req_valid  in  1  core request valid.
- req_ready  out  1  bridge accepts request.
- req_wr  in  1  1 = write, 0 = read.
- req_addr  in  ADDRW  byte address.
- req_wdata  in  XLEN  write data.
- req_strb  in  XLEN/8  byte enables.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  core accepts response.
- rsp_rdata  out  XLEN  read data; 0 for writes and errors.
- rsp_err  out  1  1 = decode error or timeout.
- mst_en  out  1  IO access enable.
- mst_wr  out  1  IO write.
- mst_addr  out  ADDRW  IO address, passed through unmodified (absolute).
- mst_wdata  out  XLEN  IO write data.
- mst_strb  out  XLEN/8  IO byte enables.
- mst_rdata  in  XLEN  IO read data, valid when mst_ready=1.
- mst_ready  in  1  IO access complete.

Behaviour:
- Reset (aresetn=0 at a clock edge):
  - State goes to IDLE.
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - mst_en=0, mst_wr=0, mst_addr=0, mst_wdata=0, mst_strb=0.
  - Watchdog counter=0.
  - Reset mid-access drops mst_en the following cycle; the pending response is lost.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready=1 (registered, asserted from the first cycle after reset release).
  - On req_valid&req_ready, latch wr/addr/wdata/strb.
  - Address hit: mst_en=1 next cycle, go to ACCESS.
  - Address miss: no bus activity; load rsp_err=1, rsp_rdata=0; go to RESP.
- ACCESS:
  - req_ready=0; mst_en and all mst_* payload held stable until mst_ready=1.
  - On mst_ready=1: capture mst_rdata (reads) or 0 (writes), rsp_err=0; drop mst_en next cycle; go to RESP.
  - Minimum latency is 1 cycle from acceptance to mst_en=1, plus 1 cycle from mst_ready to rsp_valid=1.
- RESP:
  - rsp_valid=1; rsp_rdata/rsp_err held stable until rsp_ready=1.
  - On handshake: rsp_valid=0, go to IDLE; req_ready=1 the cycle after.
  - At most one outstanding request; no request is accepted while RESP is pending.
  - Back-to-back throughput is 1 request per 4 cycles with zero-wait slave and rsp_ready tied to 1.
- mst_ready while mst_en=0 is ignored.
- Window compare uses ADDRW+1-bit arithmetic, so IO_BASE+IO_SIZE = 2^ADDRW does not wrap.
  - Address IO_BASE+IO_SIZE-1 hits; IO_BASE+IO_SIZE misses.
- Misaligned addresses and partial strobes are forwarded unchanged (slave decides).

Optional Feature:
- Macro: FRISCV_IO_BRIDGE_TIMEOUT_EN.
- Defined:
  - Watchdog counter clears on entering ACCESS and increments each ACCESS cycle with mst_ready=0.
  - When the count reaches TIMEOUT: drop mst_en next cycle, go to RESP with rsp_err=1, rsp_rdata=0.
  - mst_ready=1 on the same cycle the count reaches TIMEOUT wins: normal completion, rsp_err=0.
- Not defined:
  - No counter is synthesized; ACCESS waits indefinitely for mst_ready.
  - TIMEOUT is unused.

Test Plan:
- Write hit: req addr=0x0004, wdata=0xDEADBEEF, strb=0xF, slave ready after 3 cycles -> mst_en high 3 cycles with payload stable, mst_wr=1; then rsp_valid=1, rsp_err=0, rsp_rdata=0.
- Read hit with backpressure: req addr=0x0400, slave returns 0x12345678 with immediate ready, rsp_ready low 5 cycles -> rsp_valid held, rsp_rdata=0x12345678 stable, req_ready=0 until handshake.
- Decode miss: IO_BASE=0, IO_SIZE=2048, read addr=0x0800 -> mst_en never asserts; rsp_err=1, rsp_rdata=0 one cycle after acceptance. Addr 0x07FF -> bus access.
- Timeout (macro defined, TIMEOUT=4): read to a silent slave -> mst_en high exactly 4 cycles, then rsp_err=1. Repeat with mst_ready on the 4th cycle -> rsp_err=0.
- Reset mid-access: aresetn=0 during ACCESS -> mst_en=0 and rsp_valid=0 after the clock edge; after release, a new write completes normally.
- Back-to-back: 10 alternating writes/reads, zero-wait slave, rsp_ready=1 -> 10 responses in order, one every 4 cycles, data matches the scoreboard.

Source files
------------

// File: rtl/friscv_io_bridge.sv
// friscv_io_bridge: request/response front end of the IO peripheral subsystem.
// Takes one load/store at a time from the core, decodes it against the IO window,
// drives the IO master port until the slave completes, and returns one response.
// Optional build macro: FRISCV_IO_BRIDGE_TIMEOUT_EN enables the bus watchdog that
// turns a silent slave into an error response after TIMEOUT cycles.
module friscv_io_bridge #(
  parameter int ADDRW   = 16,
  parameter int XLEN    = 32,
  parameter int IO_BASE = 0,
  parameter int IO_SIZE = 2048,
  parameter int TIMEOUT = 255
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDRW-1:0]  req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [XLEN/8-1:0] req_strb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic              mst_en,
  output logic              mst_wr,
  output logic [ADDRW-1:0]  mst_addr,
  output logic [XLEN-1:0]   mst_wdata,
  output logic [XLEN/8-1:0] mst_strb,
  input  logic [XLEN-1:0]   mst_rdata,
  input  logic              mst_ready
);

  localparam int STRBW = XLEN / 8;

  // Window compare is done one bit wider than the address so that a window
  // ending exactly at 2^ADDRW does not wrap. Subtracting the base first turns
  // the two-sided range check into a single unsigned compare: addresses below
  // the base wrap to values far above IO_SIZE.
  localparam logic [ADDRW:0] WIN_BASE = (ADDRW+1)'(IO_BASE);
  localparam logic [ADDRW:0] WIN_SIZE = (ADDRW+1)'(IO_SIZE);

  if (TIMEOUT < 1) begin : g_timeout_check
    $error("friscv_io_bridge: TIMEOUT must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic               req_ready_s;
  logic               rsp_valid_s;
  logic [XLEN-1:0]    rsp_rdata_s;
  logic               rsp_err_s;
  logic               mst_en_s;
  logic               mst_wr_s;
  logic [ADDRW-1:0]   mst_addr_s;
  logic [XLEN-1:0]    mst_wdata_s;
  logic [STRBW-1:0]   mst_strb_s;
  logic [ADDRW:0]     offset_s;
  logic               hit_s;

`ifdef FRISCV_IO_BRIDGE_TIMEOUT_EN
  localparam int           CW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_s;
`endif

  // Address decode of the incoming request against the IO window.
  always_comb begin
    offset_s = {1'b0, req_addr} - WIN_BASE;
    hit_s    = (offset_s < WIN_SIZE);
  end

  // Next-state and next-output computation; every register holds by default.
  always_comb begin
    state_s     = state_r;
    req_ready_s = 1'b0;
    rsp_valid_s = rsp_valid;
    rsp_rdata_s = rsp_rdata;
    rsp_err_s   = rsp_err;
    mst_en_s    = mst_en;
    mst_wr_s    = mst_wr;
    mst_addr_s  = mst_addr;
    mst_wdata_s = mst_wdata;
    mst_strb_s  = mst_strb;
`ifdef FRISCV_IO_BRIDGE_TIMEOUT_EN
    cnt_s       = cnt_r;
`endif
    case (state_r)
      IDLE: begin
        if (req_valid && req_ready) begin
          // Payload is latched on both hit and miss; on a miss mst_en stays low
          // so the slave never sees it.
          mst_wr_s    = req_wr;
          mst_addr_s  = req_addr;
          mst_wdata_s = req_wdata;
          mst_strb_s  = req_strb;
          if (hit_s) begin
            mst_en_s = 1'b1;
            state_s  = ACCESS;
`ifdef FRISCV_IO_BRIDGE_TIMEOUT_EN
            cnt_s    = {CW{1'b0}};
`endif
          end else begin
            rsp_valid_s = 1'b1;
            rsp_err_s   = 1'b1;
            rsp_rdata_s = {XLEN{1'b0}};
            state_s     = RESP;
          end
        end else begin
          // Ready rises one cycle after arriving in IDLE, giving the 4-cycle cadence.
          req_ready_s = 1'b1;
        end
      end
      ACCESS: begin
        if (mst_ready && mst_en) begin
          // Completion wins over a watchdog expiry in the same cycle.
          mst_en_s    = 1'b0;
          rsp_valid_s = 1'b1;
          rsp_err_s   = 1'b0;
          rsp_rdata_s = mst_wr ? {XLEN{1'b0}} : mst_rdata;
          state_s     = RESP;
        end else begin
`ifdef FRISCV_IO_BRIDGE_TIMEOUT_EN
          if (cnt_r == TO_LAST) begin
            mst_en_s    = 1'b0;
            rsp_valid_s = 1'b1;
            rsp_err_s   = 1'b1;
            rsp_rdata_s = {XLEN{1'b0}};
            state_s     = RESP;
          end else begin
            cnt_s = cnt_r + CW'(1);
          end
`else
          state_s = ACCESS;
`endif
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_s = 1'b0;
          state_s     = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s     = IDLE;
        rsp_valid_s = 1'b0;
        mst_en_s    = 1'b0;
      end
    endcase
  end

  // State and registered-output update with synchronous active-low reset.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_r   <= IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= {XLEN{1'b0}};
      rsp_err   <= 1'b0;
      mst_en    <= 1'b0;
      mst_wr    <= 1'b0;
      mst_addr  <= {ADDRW{1'b0}};
      mst_wdata <= {XLEN{1'b0}};
      mst_strb  <= {STRBW{1'b0}};
    end else begin
      state_r   <= state_s;
      req_ready <= req_ready_s;
      rsp_valid <= rsp_valid_s;
      rsp_rdata <= rsp_rdata_s;
      rsp_err   <= rsp_err_s;
      mst_en    <= mst_en_s;
      mst_wr    <= mst_wr_s;
      mst_addr  <= mst_addr_s;
      mst_wdata <= mst_wdata_s;
      mst_strb  <= mst_strb_s;
    end
  end

`ifdef FRISCV_IO_BRIDGE_TIMEOUT_EN
  // Watchdog counter register.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      cnt_r <= {CW{1'b0}};
    end else begin
      cnt_r <= cnt_s;
    end
  end
`endif

endmodule
